visaccum_ctrl: RTL and testbench
================================

Name: visaccum_ctrl

Overview:
Sequencer in front of the final visibility accumulator. It takes the interleaved real/imaginary partial-sum stream from the correlator array and tags every beat with first/last flags. The number of accumulation frames per run is loaded at start. It sequences one complete integration (count_i frames of NSUMS beats) and then reports completion. No backpressure anywhere: beats arriving when the block is not ready are dropped and flagged.

Parameters:
IBITS, 7, partial-sum bit-width (pass-through).
NSUMS, 1024, beats per frame (real+imag components, interleaved); ABITS = $clog2(NSUMS).
CBITS, 16, width of the frame-count register.

Ports:
clock  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
start_i  in  1  single-cycle pulse; begins an integration.
abort_i  in  1  single-cycle pulse; cancels the integration in progress.
count_i  in  CBITS  frames to accumulate; sampled only on an accepted start_i.
valid_i  in  1  partial-sum beat valid.
data_i  in  IBITS  partial-sum beat (real on even beats, imag on odd beats).
valid_o  out  1  beat valid toward the accumulator.
first_o  out  1  beat belongs to frame 0 (accumulator clears).
last_o  out  1  beat belongs to the final frame (accumulator emits).
data_o  out  IBITS  registered copy of data_i.
busy_o  out  1  high in RUN.
done_o  out  1  one-cycle pulse at integration completion.
drop_o  out  1  sticky flag: a valid_i beat was discarded.

Behaviour:
- Reset (async): state=IDLE. valid_o, first_o, last_o, busy_o, done_o, drop_o = 0. data_o = 0. Item and frame counters = 0.
- States: IDLE, RUN.
- IDLE -> RUN: on start_i with count_i != 0. Latches count_i into creg, clears the counters, clears drop_o. busy_o rises the following cycle.
- start_i with count_i == 0: stay in IDLE, pulse done_o the next cycle, clear drop_o, emit no beats.
- Beats in IDLE: valid_i is dropped and sets drop_o. This includes a beat coincident with the accepted start_i.
- Beats in RUN, latency 1 cycle:
  - valid_o <= valid_i; data_o <= data_i.
  - first_o <= valid_i && frame==0.
  - last_o <= valid_i && frame==creg-1.
  - Flags are 0 whenever valid_o is 0.
  - On valid_i, item increments. When item==NSUMS-1, item wraps to 0 and frame increments.
- Gaps: valid_i may deassert for any number of cycles. The counters hold and no beat is emitted.
- Completion: the accepted beat with item==NSUMS-1 and frame==creg-1 is forwarded with last_o=1. In the same cycle that beat appears on valid_o, done_o=1, busy_o=0 and the state is IDLE.
- Consecutive runs: a valid_i beat in the cycle right after the final beat is in IDLE and is dropped. start_i may arrive in that cycle.
- start_i during RUN: ignored. creg and counters are unchanged.
- abort_i during RUN: return to IDLE next cycle and clear the counters. A beat coincident with abort_i is dropped without setting drop_o. done_o does not pulse. A beat already registered in the previous cycle still completes on valid_o.
- abort_i in IDLE: no effect. abort_i and start_i together: abort wins; start is ignored.
- Width rules:
  - item is ABITS wide; its wrap is an explicit compare to NSUMS-1, so non-power-of-2 NSUMS works.
  - frame is CBITS wide; it never exceeds creg-1 while in RUN.
  - The maximum integration is 2^CBITS-1 frames.

Decomposition:
- Shared package visaccum_pkg:
  - state enum (ST_IDLE, ST_RUN);
  - default NSUMS;
  - CBITS.
  The downstream accumulator imports the same NSUMS.
- One natural sub-module: nested_counter (item/frame counter with wrap and terminal-count outputs), reusable by the output-stream logic of the accumulator.
- The FSM and flag registers stay in visaccum_ctrl.

Test Plan:
- NSUMS=4, start_i count_i=3, 12 back-to-back beats 0..11 -> valid_o 1 cycle later. first_o on beats 0-3, last_o on beats 8-11. done_o coincides with beat 11 on valid_o. drop_o=0.
- Same run with valid_i randomly gapped (50% duty) -> identical output beat/flag sequence. done_o aligns with the 12th beat output.
- count_i=1, 4 beats -> every beat has first_o=1 and last_o=1. done_o with beat 3. count_i=0 -> done_o the next cycle, no valid_o.
- Beat while IDLE, and a beat in the start_i cycle -> not forwarded, drop_o=1. A subsequent start_i clears drop_o.
- abort_i after 6 of 12 beats -> at most one further valid_o, no done_o, busy_o=0. A new start_i count_i=2 restarts with first_o on its beats 0-3.
- reset asserted mid-run (asynchronously, between clock edges) -> all outputs 0 immediately. After release, the block stays in IDLE until start_i.

Source files
------------

// File: rtl/visaccum_pkg.sv
// rtl/visaccum_pkg.sv - shared types and sizing for the visibility accumulator path
package visaccum_pkg;

    // Beats per frame; the downstream accumulator uses the same value
    localparam int NSUMS_DEF = 1024;
    // Width of the frame-count register
    localparam int CBITS_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Counter width for n items; never less than one bit
    function automatic int abits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/visaccum_nested_counter.sv
// rtl/visaccum_nested_counter.sv - item/frame counter with explicit item wrap
import visaccum_pkg::*;

module nested_counter #(
    parameter int NSUMS = NSUMS_DEF,
    parameter int CBITS = CBITS_DEF,
    parameter int ABITS = abits(NSUMS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [ABITS-1:0] item_o,
    output logic [CBITS-1:0] frame_o
);

    // Explicit compare so a non-power-of-2 NSUMS wraps correctly
    localparam logic [ABITS-1:0] ITEM_MAX = ABITS'(NSUMS - 1);

    logic [ABITS-1:0] item_q, item_d;
    logic [CBITS-1:0] frame_q, frame_d;

    // Next-count: clear has priority, item wraps into a frame increment
    always_comb begin
        item_d  = item_q;
        frame_d = frame_q;
        if (clear_i) begin
            item_d  = '0;
            frame_d = '0;
        end else if (inc_i) begin
            if (item_q == ITEM_MAX) begin
                item_d  = '0;
                frame_d = frame_q + CBITS'(1);
            end else begin
                item_d = item_q + ABITS'(1);
            end
        end
    end

    // Count registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            item_q  <= '0;
            frame_q <= '0;
        end else begin
            item_q  <= item_d;
            frame_q <= frame_d;
        end
    end

    assign item_o  = item_q;
    assign frame_o = frame_q;

endmodule

// File: rtl/visaccum_ctrl.sv
// rtl/visaccum_ctrl.sv - sequences one integration and tags beats with first/last
import visaccum_pkg::*;

module visaccum_ctrl #(
    parameter int IBITS = 7,
    parameter int NSUMS = NSUMS_DEF,
    parameter int CBITS = CBITS_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CBITS-1:0] count_i,
    input  logic             valid_i,
    input  logic [IBITS-1:0] data_i,
    output logic             valid_o,
    output logic             first_o,
    output logic             last_o,
    output logic [IBITS-1:0] data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             drop_o
);

    localparam int ABITS = abits(NSUMS);
    localparam logic [ABITS-1:0] ITEM_MAX = ABITS'(NSUMS - 1);

    state_e           state_q, state_d;
    logic [CBITS-1:0] creg_q, creg_d;
    logic             valid_q, valid_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic [IBITS-1:0] data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             drop_q, drop_d;

    logic             cnt_clear;
    logic             cnt_inc;
    logic [ABITS-1:0] item;
    logic [CBITS-1:0] frame;
    logic             last_item;
    logic             last_frame;

    nested_counter #(
        .NSUMS (NSUMS),
        .CBITS (CBITS),
        .ABITS (ABITS)
    ) u_cnt (
        .clock   (clock),
        .reset   (reset),
        .clear_i (cnt_clear),
        .inc_i   (cnt_inc),
        .item_o  (item),
        .frame_o (frame)
    );

    assign last_item  = (item == ITEM_MAX);
    assign last_frame = (frame == creg_q - CBITS'(1));

    // Next-state, beat tagging and flag logic
    always_comb begin
        state_d   = state_q;
        creg_d    = creg_q;
        valid_d   = 1'b0;
        first_d   = 1'b0;
        last_d    = 1'b0;
        data_d    = data_i;
        busy_d    = busy_q;
        done_d    = 1'b0;
        drop_d    = drop_q;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A start (even when accepted) cannot rescue a coincident beat
                if (!abort_i && start_i) begin
                    drop_d    = valid_i;
                    cnt_clear = 1'b1;
                    if (count_i != '0) begin
                        state_d = ST_RUN;
                        creg_d  = count_i;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (valid_i) begin
                    drop_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    // Coincident beat is discarded silently on abort
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    cnt_clear = 1'b1;
                end else if (valid_i) begin
                    valid_d = 1'b1;
                    first_d = (frame == '0);
                    last_d  = last_frame;
                    cnt_inc = 1'b1;
                    if (last_item && last_frame) begin
                        state_d   = ST_IDLE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        cnt_clear = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            creg_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            creg_q  <= creg_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign valid_o = valid_q;
    assign first_o = first_q;
    assign last_o  = last_q;
    assign data_o  = data_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign drop_o  = drop_q;

endmodule

// File: tb/tb_visaccum_ctrl.sv
// tb/tb_visaccum_ctrl.sv - directed vector bench for visaccum_ctrl
module tb_visaccum_ctrl;

    localparam int IBITS = 7;
    localparam int NSUMS = 4;
    localparam int CBITS = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
    logic [CBITS-1:0] count_i = '0;
    logic             valid_i = 1'b0;
    logic [IBITS-1:0] data_i = '0;
    logic             valid_o, first_o, last_o, busy_o, done_o, drop_o;
    logic [IBITS-1:0] data_o;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic             start;
        logic             abort;
        logic [CBITS-1:0] count;
        logic             valid;
        logic [IBITS-1:0] data;
        logic             ev;
        logic             ef;
        logic             el;
        logic             eb;
        logic             ed;
        logic             edr;
    } vec_t;

    vec_t vq[$];

    visaccum_ctrl #(
        .IBITS (IBITS),
        .NSUMS (NSUMS),
        .CBITS (CBITS)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start_i (start_i),
        .abort_i (abort_i),
        .count_i (count_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .valid_o (valid_o),
        .first_o (first_o),
        .last_o  (last_o),
        .data_o  (data_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .drop_o  (drop_o)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic s, input logic a, input int c, input logic v, input int d,
                       input logic ev, input logic ef, input logic el,
                       input logic eb, input logic ed, input logic edr);
        vec_t x;
        x.start = s; x.abort = a; x.count = CBITS'(c); x.valid = v; x.data = IBITS'(d);
        x.ev = ev; x.ef = ef; x.el = el; x.eb = eb; x.ed = ed; x.edr = edr;
        vq.push_back(x);
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic ef, input logic el,
                           input logic eb, input logic ed, input logic edr);
        chk({tag, ".valid"}, 32'(valid_o), 32'(ev));
        chk({tag, ".first"}, 32'(first_o), 32'(ef));
        chk({tag, ".last"},  32'(last_o),  32'(el));
        chk({tag, ".busy"},  32'(busy_o),  32'(eb));
        chk({tag, ".done"},  32'(done_o),  32'(ed));
        chk({tag, ".drop"},  32'(drop_o),  32'(edr));
    endtask

    initial begin
        int sent;
        int prev;
        int cyc;
        bit fin;

        // count=3 back-to-back, then start(count=1) in the cycle after the final beat
        add(1,0,3,0,0, 0,0,0,1,0,0);
        for (int k = 0; k < 12; k++)
            add(0,0,0,1,k, 1, k < 4, k >= 8, k != 11, k == 11, 0);
        add(1,0,1,1,50, 0,0,0,1,0,1);
        for (int k = 0; k < 4; k++)
            add(0,0,0,1,20+k, 1,1,1, k != 3, k == 3, 1);
        // count=0, idle beats, abort in idle
        add(1,0,0,0,0, 0,0,0,0,1,0);
        add(0,0,0,0,0, 0,0,0,0,0,0);
        add(0,0,0,1,33, 0,0,0,0,0,1);
        add(0,1,0,1,34, 0,0,0,0,0,1);
        // abort after 6 beats
        add(1,0,3,0,0, 0,0,0,1,0,0);
        for (int k = 0; k < 6; k++)
            add(0,0,0,1,k, 1, k < 4, 0, 1, 0, 0);
        add(0,1,0,1,6, 0,0,0,0,0,0);
        add(0,0,0,0,0, 0,0,0,0,0,0);
        add(1,1,2,0,0, 0,0,0,0,0,0);
        // restart count=2 with a gap and an ignored start mid-run
        add(1,0,2,0,0, 0,0,0,1,0,0);
        for (int k = 0; k < 8; k++) begin
            if (k == 2) add(0,0,0,0,9, 0,0,0,1,0,0);
            add(k == 3, 0, 5, 1, 40+k, 1, k < 4, k >= 4, k != 7, k == 7, 0);
        end
        add(0,0,0,1,70, 0,0,0,0,0,1);

        // reset state
        #12;
        chk_out("reset", 0,0,0,0,0,0);
        chk("reset.data", 32'(data_o), 0);
        reset = 1'b0;

        foreach (vq[i]) begin
            start_i = vq[i].start;
            abort_i = vq[i].abort;
            count_i = vq[i].count;
            valid_i = vq[i].valid;
            data_i  = vq[i].data;
            tick();
            chk_out($sformatf("vec%0d", i), vq[i].ev, vq[i].ef, vq[i].el, vq[i].eb, vq[i].ed, vq[i].edr);
            chk($sformatf("vec%0d.data", i), 32'(data_o), 32'(vq[i].data));
        end

        // randomly gapped count=3 run
        start_i = 1; count_i = 3; valid_i = 0; abort_i = 0;
        tick();
        chk("gap.start_busy", 32'(busy_o), 1);
        chk("gap.start_drop", 32'(drop_o), 0);
        start_i = 0;
        sent = 0;
        fin = 0;
        for (cyc = 0; cyc < 300 && !fin; cyc++) begin
            valid_i = (sent < 12) ? 1'($urandom_range(0, 1)) : 1'b0;
            data_i  = IBITS'(60 + sent);
            prev    = valid_i ? sent : -1;
            if (valid_i) sent++;
            tick();
            chk("gap.valid", 32'(valid_o), 32'(prev >= 0));
            if (prev >= 0) begin
                chk("gap.data",  32'(data_o),  32'(60 + prev));
                chk("gap.first", 32'(first_o), 32'(prev < 4));
                chk("gap.last",  32'(last_o),  32'(prev >= 8));
                chk("gap.done",  32'(done_o),  32'(prev == 11));
                if (prev == 11) fin = 1;
            end else begin
                chk("gap.done_idle", 32'(done_o), 0);
            end
        end
        chk("gap.finished", 32'(fin), 1);
        valid_i = 0;
        tick();
        chk("gap.busy_after", 32'(busy_o), 0);

        // asynchronous reset mid-run
        start_i = 1; count_i = 3;
        tick();
        start_i = 0;
        for (int k = 0; k < 5; k++) begin
            valid_i = 1; data_i = IBITS'(k);
            tick();
        end
        chk("arst.pre_busy", 32'(busy_o), 1);
        #3;
        reset = 1'b1;
        #1;
        chk_out("arst", 0,0,0,0,0,0);
        chk("arst.data", 32'(data_o), 0);
        #1;
        reset = 1'b0;
        valid_i = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("arst.idle_busy", 32'(busy_o), 0);
            chk("arst.idle_valid", 32'(valid_o), 0);
        end
        start_i = 1; count_i = 1;
        tick();
        start_i = 0;
        for (int k = 0; k < 4; k++) begin
            valid_i = 1; data_i = IBITS'(90 + k);
            tick();
            chk_out($sformatf("arst.run%0d", k), 1, 1, 1, k != 3, k == 3, 0);
            chk("arst.run_data", 32'(data_o), 32'(90 + k));
        end
        valid_i = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
